uart_echo_sequencer: RTL

Autonomous master for the peripheral register bus (wr_o / reg_sel_o / addr_o / data_o, combinational read-back on rdata_i). It polls the control register for new_rx, reads the received byte, writes it to the TX data register, triggers send (clearing new_rx in the same write), then waits for send completion. It is the hardware loopback engine that replaces button-driven bus sequencing on the board.

---
 rtl/uart_bus_pkg.sv | 22 ++
 rtl/uart_echo_sequencer_down_counter.sv | 31 +++
 rtl/uart_echo_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_bus_pkg.sv
// Shared register-map constants and the echo sequencer state encoding.
package uart_bus_pkg;

  localparam logic REG_SEL_CTRL = 1'b0;
  localparam logic REG_SEL_DATA = 1'b1;
  localparam logic ADDR_TX      = 1'b0;
  localparam logic ADDR_RX      = 1'b1;

  localparam int CTRL_SEND_BIT   = 0;
  localparam int CTRL_NEW_RX_BIT = 1;

  typedef enum logic [2:0] {
    IDLE,
    POLL_CTRL,
    READ_RX,
    WRITE_TX,
    START_SEND,
    WAIT_SEND,
    DONE
  } echo_state_t;

endpackage

// File: rtl/uart_echo_sequencer_down_counter.sv
// Loadable down counter that saturates at zero; flags zero and the final count of one.
module down_counter #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [WIDTH-1:0] count_reg;

  // Load has priority over decrement; decrementing stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= RESET_VALUE;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && !zero) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);
  assign last = (count_reg == WIDTH'(1));

endmodule

// File: rtl/uart_echo_sequencer.sv
// Bus master that loops every received UART byte back to the transmitter.
module uart_echo_sequencer
  import uart_bus_pkg::*;
#(
  parameter int POLL_DIV       = 1000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        clear_err_i,
  input  logic [31:0] rdata_i,
  output logic        wr_o,
  output logic        reg_sel_o,
  output logic        addr_o,
  output logic [31:0] data_o,
  output logic        busy_o,
  output logic [7:0]  echo_count_o,
  output logic [7:0]  last_byte_o,
  output logic        err_o
);

  localparam int POLL_W = $clog2(POLL_DIV + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  echo_state_t state_reg, state_next;
  logic [7:0]  rx_byte_reg;
  logic        poll_zero, poll_last, poll_load, poll_dec;
  logic        to_zero, to_last, to_load, to_dec;
  logic        send_busy, timeout_hit;
  logic        unused_rdata;

  // Only the low byte and the two control flags are meaningful on read-back.
  assign unused_rdata = ^rdata_i[31:8];

  assign send_busy   = rdata_i[CTRL_SEND_BIT];
  assign timeout_hit = (state_reg == WAIT_SEND) && send_busy && (to_last || to_zero);

  // The poll timer only runs in IDLE while enabled; anywhere else it sits at the reload value.
  assign poll_load = (state_reg != IDLE) || !enable_i;
  assign poll_dec  = (state_reg == IDLE) && enable_i;

  assign to_load = (state_reg == START_SEND);
  assign to_dec  = (state_reg == WAIT_SEND) && send_busy;

  down_counter #(
    .WIDTH      (POLL_W),
    .RESET_VALUE(POLL_W'(POLL_DIV))
  ) poll_timer (
    .clk       (clk_i),
    .rst       (rst_i),
    .load      (poll_load),
    .load_value(POLL_W'(POLL_DIV)),
    .dec       (poll_dec),
    .zero      (poll_zero),
    .last      (poll_last)
  );

  down_counter #(
    .WIDTH      (TO_W),
    .RESET_VALUE('0)
  ) send_timer (
    .clk       (clk_i),
    .rst       (rst_i),
    .load      (to_load),
    .load_value(TO_W'(TIMEOUT_CYCLES)),
    .dec       (to_dec),
    .zero      (to_zero),
    .last      (to_last)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and Moore-decoded bus outputs.
  always_comb begin
    state_next = state_reg;
    wr_o       = 1'b0;
    reg_sel_o  = REG_SEL_CTRL;
    addr_o     = ADDR_TX;
    data_o     = '0;
    case (state_reg)
      IDLE: begin
        if (enable_i && (poll_last || poll_zero)) state_next = POLL_CTRL;
      end
      POLL_CTRL: begin
        state_next = rdata_i[CTRL_NEW_RX_BIT] ? READ_RX : IDLE;
      end
      READ_RX: begin
        reg_sel_o  = REG_SEL_DATA;
        addr_o     = ADDR_RX;
        state_next = WRITE_TX;
      end
      WRITE_TX: begin
        wr_o       = 1'b1;
        reg_sel_o  = REG_SEL_DATA;
        addr_o     = ADDR_TX;
        data_o     = {24'd0, rx_byte_reg};
        state_next = START_SEND;
      end
      START_SEND: begin
        // Setting send while writing new_rx = 0 acknowledges the received byte.
        wr_o       = 1'b1;
        data_o     = 32'(1) << CTRL_SEND_BIT;
        state_next = WAIT_SEND;
      end
      WAIT_SEND: begin
        if (!send_busy)       state_next = DONE;
        else if (timeout_hit) state_next = IDLE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Received byte capture, echo bookkeeping and the sticky timeout flag (set beats clear).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_byte_reg  <= '0;
      echo_count_o <= '0;
      last_byte_o  <= '0;
      err_o        <= 1'b0;
    end else begin
      if (state_reg == READ_RX) rx_byte_reg <= rdata_i[7:0];
      if (state_reg == DONE) begin
        echo_count_o <= echo_count_o + 8'd1;
        last_byte_o  <= rx_byte_reg;
      end
      if (timeout_hit)      err_o <= 1'b1;
      else if (clear_err_i) err_o <= 1'b0;
    end
  end

  assign busy_o = (state_reg != IDLE);

endmodule
